game_controller: RTL and testbench

Game-flow sequencer for the bricks game. It sits between the debounced buttons and the pixel generator, and decides when the ball moves, when the ball and bricks are reloaded, and when the game ends. It owns the score (two BCD digits), which feeds the 7-segment scanner directly, and it owns the remaining-lives count. All timing is counted in video frames, using a one-cycle frame_tick pulse from the VGA timing block.

---
 rtl/game_pkg.sv | 26 ++
 rtl/bcd_score2.sv | 48 ++++
 rtl/game_controller.sv | 163 ++++++++++++++++
 tb/tb_game_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : game_pkg
//  Purpose  : Shared state encoding and frame-timing constants for the game.
//  Revision : 1.0
// ============================================================================
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LOST  = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_t;

    localparam int c_BCD_W        = 4;
    localparam int c_LIVES        = 3;
    localparam int c_SERVE_FRAMES = 120;
    localparam int c_HOLD_FRAMES  = 180;
    localparam int c_FCNT_W       = 8;

endpackage
`default_nettype wire

// File: rtl/bcd_score2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bcd_score2
//  Purpose  : Two-digit BCD score counter, saturating at 99; clr beats inc.
//  Revision : 1.0
// ============================================================================
module bcd_score2
    import game_pkg::*;
(
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [c_BCD_W-1:0] ones,
    output logic [c_BCD_W-1:0] tens
);

    localparam logic [c_BCD_W-1:0] c_DIGIT_MAX = c_BCD_W'(9);

    logic [c_BCD_W-1:0] r_ones;
    logic [c_BCD_W-1:0] r_tens;
    logic               w_at_max;

    assign w_at_max = (r_ones == c_DIGIT_MAX) && (r_tens == c_DIGIT_MAX);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_ones <= '0;
            r_tens <= '0;
        end else if (clr) begin
            r_ones <= '0;
            r_tens <= '0;
        end else if (inc && !w_at_max) begin
            if (r_ones == c_DIGIT_MAX) begin
                r_ones <= '0;
                r_tens <= r_tens + 1'b1;
            end else begin
                r_ones <= r_ones + 1'b1;
            end
        end
    end

    assign ones = r_ones;
    assign tens = r_tens;

endmodule
`default_nettype wire

// File: rtl/game_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : game_controller
//  Purpose  : Bricks game-flow sequencer: serve timing, lives, score, end hold.
//  Revision : 1.0
// ============================================================================
module game_controller
    import game_pkg::*;
#(
    parameter int LIVES        = c_LIVES,
    parameter int SERVE_FRAMES = c_SERVE_FRAMES,
    parameter int HOLD_FRAMES  = c_HOLD_FRAMES,
    parameter int FCNT_W       = c_FCNT_W
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               start,
    input  logic               frame_tick,
    input  logic               brick_hit,
    input  logic               ball_miss,
    input  logic               bricks_cleared,
    output logic               ball_run,
    output logic               ball_reload,
    output logic               bricks_reload,
    output logic [2:0]         state,
    output logic [1:0]         lives,
    output logic [c_BCD_W-1:0] skor_birler,
    output logic [c_BCD_W-1:0] skor_onlar,
    output logic               game_over,
    output logic               win
);

    localparam logic [FCNT_W-1:0] c_SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
    localparam logic [FCNT_W-1:0] c_HOLD_MAX   = FCNT_W'(HOLD_FRAMES);
    localparam logic [1:0]        c_LIVES_INIT = 2'(LIVES);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_start_q;
    logic              w_start_rise;
    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_nxt;
    logic [1:0]        r_lives;
    logic [1:0]        w_lives_nxt;
    logic              r_ball_reload;
    logic              r_bricks_reload;
    logic              w_ball_reload_nxt;
    logic              w_bricks_reload_nxt;
    logic              w_new_game;
    logic              w_score_inc;

    assign w_start_rise = start & ~r_start_q;

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_fcnt_nxt          = r_fcnt;
        w_lives_nxt         = r_lives;
        w_new_game          = 1'b0;
        w_ball_reload_nxt   = 1'b0;
        w_bricks_reload_nxt = 1'b0;
        w_score_inc         = 1'b0;
        ball_run            = 1'b0;
        game_over           = 1'b0;
        win                 = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_new_game = w_start_rise;
            end
            ST_SERVE: begin
                if (frame_tick) begin
                    if (r_fcnt == c_SERVE_LAST) begin
                        w_state_nxt = ST_PLAY;
                        w_fcnt_nxt  = '0;
                    end else begin
                        w_fcnt_nxt = r_fcnt + 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                ball_run    = 1'b1;
                w_score_inc = brick_hit;
                if (bricks_cleared) begin
                    w_state_nxt = ST_WIN;
                end else if (ball_miss) begin
                    w_lives_nxt = r_lives - 1'b1;
                    w_state_nxt = ST_LOST;
                end
            end
            ST_LOST: begin
                w_fcnt_nxt = '0;
                if (r_lives == 2'd0) begin
                    w_state_nxt = ST_OVER;
                end else begin
                    w_ball_reload_nxt = 1'b1;
                    w_state_nxt       = ST_SERVE;
                end
            end
            ST_OVER, ST_WIN: begin
                game_over = (r_state == ST_OVER);
                win       = (r_state == ST_WIN);
                // Restart is locked out until the hold counter has saturated.
                if (w_start_rise && (r_fcnt >= c_HOLD_MAX)) begin
                    w_new_game = 1'b1;
                end else if (frame_tick && (r_fcnt < c_HOLD_MAX)) begin
                    w_fcnt_nxt = r_fcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_new_game) begin
            w_state_nxt         = ST_SERVE;
            w_fcnt_nxt          = '0;
            w_lives_nxt         = c_LIVES_INIT;
            w_ball_reload_nxt   = 1'b1;
            w_bricks_reload_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_start_q       <= 1'b0;
            r_fcnt          <= '0;
            r_lives         <= c_LIVES_INIT;
            r_ball_reload   <= 1'b0;
            r_bricks_reload <= 1'b0;
        end else begin
            r_start_q       <= start;
            r_fcnt          <= w_fcnt_nxt;
            r_lives         <= w_lives_nxt;
            r_ball_reload   <= w_ball_reload_nxt;
            r_bricks_reload <= w_bricks_reload_nxt;
        end
    end

    bcd_score2 u_score (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .clr        (w_new_game),
        .inc        (w_score_inc),
        .ones       (skor_birler),
        .tens       (skor_onlar)
    );

    assign state         = r_state;
    assign lives         = r_lives;
    assign ball_reload   = r_ball_reload;
    assign bricks_reload = r_bricks_reload;

endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_game_controller
//  Purpose  : Scoreboard bench for game_controller against a game-rule model.
//  Revision : 1.0
// ============================================================================
module tb_game_controller;

    localparam int L  = 3;
    localparam int SF = 120;
    localparam int HF = 180;

    logic       clk_100MHz = 1'b0;
    logic       reset;
    logic       start;
    logic       frame_tick;
    logic       brick_hit;
    logic       ball_miss;
    logic       bricks_cleared;
    logic       ball_run;
    logic       ball_reload;
    logic       bricks_reload;
    logic [2:0] state;
    logic [1:0] lives;
    logic [3:0] skor_birler;
    logic [3:0] skor_onlar;
    logic       game_over;
    logic       win;

    game_controller dut (
        .clk_100MHz     (clk_100MHz),
        .reset          (reset),
        .start          (start),
        .frame_tick     (frame_tick),
        .brick_hit      (brick_hit),
        .ball_miss      (ball_miss),
        .bricks_cleared (bricks_cleared),
        .ball_run       (ball_run),
        .ball_reload    (ball_reload),
        .bricks_reload  (bricks_reload),
        .state          (state),
        .lives          (lives),
        .skor_birler    (skor_birler),
        .skor_onlar     (skor_onlar),
        .game_over      (game_over),
        .win            (win)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] lv;
        logic [3:0] ones;
        logic [3:0] tens;
        logic       run;
        logic       bl;
        logic       br;
        logic       go;
        logic       wn;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   br_seen = 0;
    int   bl_seen = 0;

    // Game-rule model: mode number, frame count, lives and score as integers.
    int m_st, m_cnt, m_lives, m_score;
    bit m_sq, m_br, m_bl;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit   rise;
        bit   ng;
        exp_t e;
        if (reset) begin
            m_st = 0; m_cnt = 0; m_lives = L; m_score = 0;
            m_sq = 0; m_br = 0; m_bl = 0;
        end else begin
            rise = start && !m_sq;
            m_sq = start;
            m_br = 0; m_bl = 0; ng = 0;
            case (m_st)
                0: ng = rise;
                1: if (frame_tick) begin
                       m_cnt++;
                       if (m_cnt == SF) begin m_st = 2; m_cnt = 0; end
                   end
                2: begin
                       if (brick_hit && m_score < 99) m_score++;
                       if (bricks_cleared) m_st = 5;
                       else if (ball_miss) begin m_lives--; m_st = 3; end
                   end
                3: begin
                       m_cnt = 0;
                       if (m_lives == 0) m_st = 4;
                       else begin m_bl = 1; m_st = 1; end
                   end
                default: begin
                       if (rise && m_cnt >= HF) ng = 1;
                       else if (frame_tick && m_cnt < HF) m_cnt++;
                   end
            endcase
            if (ng) begin
                m_st = 1; m_cnt = 0; m_lives = L; m_score = 0; m_br = 1; m_bl = 1;
            end
        end
        e.st   = 3'(m_st);
        e.lv   = 2'(m_lives);
        e.ones = 4'(m_score % 10);
        e.tens = 4'(m_score / 10);
        e.run  = (m_st == 2);
        e.bl   = m_bl;
        e.br   = m_br;
        e.go   = (m_st == 4);
        e.wn   = (m_st == 5);
        exp_q.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit s, input bit t, input bit h, input bit m, input bit c);
        @(negedge clk_100MHz);
        reset = r; start = s; frame_tick = t; brick_hit = h; ball_miss = m; bricks_cleared = c;
        model_step();
    endtask

    task automatic serve(input int n);
        repeat (n) cyc(0, 0, 1, 0, 0, 0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_lives"}, lives, L);
        chk({tag, "_ones"}, skor_birler, 0);
        chk({tag, "_tens"}, skor_onlar, 0);
        chk({tag, "_run"}, ball_run, 0);
        chk({tag, "_reloads"}, {ball_reload, bricks_reload}, 0);
        chk({tag, "_go_win"}, {game_over, win}, 0);
    endtask

    always @(posedge clk_100MHz) begin
        exp_t e;
        #1;
        if (ball_reload)   bl_seen++;
        if (bricks_reload) br_seen++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", state, e.st);
            chk("lives", lives, e.lv);
            chk("skor_birler", skor_birler, e.ones);
            chk("skor_onlar", skor_onlar, e.tens);
            chk("ball_run", ball_run, e.run);
            chk("ball_reload", ball_reload, e.bl);
            chk("bricks_reload", bricks_reload, e.br);
            chk("game_over", game_over, e.go);
            chk("win", win, e.wn);
        end
    end

    initial begin
        reset = 1; start = 0; frame_tick = 0; brick_hit = 0; ball_miss = 0; bricks_cleared = 0;
        #1;
        chk_reset_values("por");
        repeat (3) cyc(1, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 0, 0, 0, 0, 0);

        // Holding start must yield a single new game.
        br_seen = 0; bl_seen = 0;
        repeat (1000) cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("hold_start_bricks_pulses", br_seen, 1);
        chk("hold_start_ball_pulses", bl_seen, 1);

        // Hits, misses and clears during serve are ignored.
        repeat (SF) cyc(0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        cyc(0, 0, 0, 0, 0, 0);

        repeat (23) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("score_23", {skor_onlar, skor_birler}, 8'h23);
        repeat (110) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0, 0);
            if (k < 2) serve(SF);
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("over_flag", game_over, 1);
        serve(10);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        serve(HF);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        serve(SF);
        repeat (4) cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("win_flag", win, 1);

        serve(HF + 5);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        serve(60);

        // Asynchronous reset mid-serve, between clock edges.
        @(negedge clk_100MHz);
        start = 0; frame_tick = 1; brick_hit = 0; ball_miss = 0; bricks_cleared = 0;
        #2 reset = 1;
        #1 chk_reset_values("async");
        model_step();
        repeat (2) cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        begin
            bit s = 0;
            for (int i = 0; i < 6000; i++) begin
                if ($urandom_range(0, 29) == 0) s = ~s;
                cyc($urandom_range(0, 1999) == 0, s,
                    $urandom_range(0, 1) == 0,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 149) == 0,
                    $urandom_range(0, 299) == 0);
            end
        end

        cyc(0, 0, 0, 0, 0, 0);
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk_100MHz);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
